// File: rtl/muldiv_unit_pkg.sv
// Shared types, op codes and helpers for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

    localparam int unsigned N     = 32;
    localparam int unsigned CNT_W = $clog2(N) + 1;

    // RV32M funct3 codes, shared with the decoder
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [N-1:0] INT_MIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    // Request captured on accept: op plus operand magnitudes and signs
    typedef struct packed {
        logic [2:0]   op;
        logic         a_neg;
        logic         b_neg;
        logic [N-1:0] a_mag;
        logic [N-1:0] b_mag;
    } md_req_t;

    // rs1 is signed for every op except MULHU, DIVU and REMU
    function automatic logic op_signed_a(input logic [2:0] f);
        return (f == MD_MUL) || (f == MD_MULH) || (f == MD_MULHSU) ||
               (f == MD_DIV) || (f == MD_REM);
    endfunction

    // rs2 is signed only for MUL, MULH, DIV and REM
    function automatic logic op_signed_b(input logic [2:0] f);
        return (f == MD_MUL) || (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_md_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module md_step
    import muldiv_unit_pkg::*;
(
    input  logic [N-1:0] acc,
    input  logic         bit_in,
    input  logic [N-1:0] operand,
    input  logic         mode,
    output logic [N:0]   acc_next,
    output logic         q_bit
);

    logic [N:0] addend;
    logic [N:0] sum;
    logic [N:0] shifted;
    logic [N:0] trial;

    // mode=0: add multiplicand when multiplier bit set; mode=1: shift in dividend bit and trial-subtract
    always_comb begin
        acc_next = '0;
        q_bit    = 1'b0;
        addend   = bit_in ? {1'b0, operand} : '0;
        sum      = {1'b0, acc} + addend;
        shifted  = {acc, bit_in};
        trial    = shifted - {1'b0, operand};
        if (mode) begin
            q_bit    = ~trial[N];
            acc_next = trial[N] ? shifted : trial;
        end else begin
            acc_next = sum;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: fixed N+2 cycle latency, busy/done handshake.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

    md_state_t      state;
    md_state_t      state_next;
    md_req_t        req;
    md_req_t        req_c;
    logic [N-1:0]   hi;
    logic [N-1:0]   lo;
    logic [CNT_W-1:0] cnt;
    logic           accept_c;

    logic [N:0]     step_acc;
    logic           step_q;
    logic           mode;

    logic [2*N-1:0] prod;
    logic [2*N-1:0] prod_fix;
    logic           sign_diff;
    logic [N-1:0]   quo_fix;
    logic [N-1:0]   rem_fix;
    logic [N-1:0]   orig_a;
    logic           div_zero;
    logic           div_ovf;
    logic [N-1:0]   fix_result_c;

    assign accept_c = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign mode     = req.op[2];

    // Decode incoming request into signs and magnitudes
    always_comb begin
        req_c       = '0;
        req_c.op    = op;
        req_c.a_neg = op_signed_a(op) & A[N-1];
        req_c.b_neg = op_signed_b(op) & B[N-1];
        req_c.a_mag = req_c.a_neg ? N'(-A) : A;
        req_c.b_mag = req_c.b_neg ? N'(-B) : B;
    end

    md_step u_step (
        .acc      (hi),
        .bit_in   (mode ? lo[N-1] : lo[0]),
        .operand  (mode ? req.b_mag : req.a_mag),
        .mode     (mode),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_CALC;
            ST_CALC: if (cnt == LAST_ITER) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_CALC : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand latch and iteration datapath; hi holds product-high/remainder, lo multiplier/quotient
    always_ff @(posedge clk) begin
        if (rst) begin
            req <= '0;
            hi  <= '0;
            lo  <= '0;
            cnt <= '0;
        end else if (accept_c) begin
            req <= req_c;
            hi  <= '0;
            lo  <= op[2] ? req_c.a_mag : req_c.b_mag;
            cnt <= '0;
        end else if (state == ST_CALC) begin
            if (mode) begin
                hi <= step_acc[N-1:0];
                lo <= {lo[N-2:0], step_q};
            end else begin
                hi <= step_acc[N:1];
                lo <= {step_acc[0], lo[N-1:1]};
            end
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Sign correction and special-case selection applied in FIX
    always_comb begin
        fix_result_c = '0;
        prod         = {hi, lo};
        sign_diff    = req.a_neg ^ req.b_neg;
        prod_fix     = sign_diff ? (2*N)'(-prod) : prod;
        quo_fix      = sign_diff ? N'(-lo) : lo;
        rem_fix      = req.a_neg ? N'(-hi) : hi;
        orig_a       = req.a_neg ? N'(-req.a_mag) : req.a_mag;
        div_zero     = (req.b_mag == '0);
        div_ovf      = req.a_neg && req.b_neg && (req.a_mag == INT_MIN) && (req.b_mag == N'(1));
        case (req.op)
            MD_MUL:                        fix_result_c = prod_fix[N-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  fix_result_c = prod_fix[2*N-1:N];
            MD_DIV, MD_DIVU:               fix_result_c = div_zero ? '1 : (div_ovf ? INT_MIN : quo_fix);
            MD_REM, MD_REMU:               fix_result_c = div_zero ? orig_a : (div_ovf ? '0 : rem_fix);
            default:                       fix_result_c = '0;
        endcase
    end

    // Registered handshake outputs and result capture at FIX->DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            busy <= (state_next == ST_CALC) || (state_next == ST_FIX);
            done <= (state_next == ST_DONE);
            if (state == ST_FIX) begin
                result <= fix_result_c;
            end
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit for the RV32M extension. It sits beside the single-cycle ALU in the EX stage. The ALU returns a result in the same cycle; this unit accepts a request, holds the pipeline through `busy`, and returns the result after a fixed latency. The hazard unit stalls IF/ID/EX while `busy` is high and captures `result` on `done`.

## Interface
- `N`, 32, operand and result width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request strobe; sampled only when the unit is not busy.
- `op`  in  3  RV32M funct3: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
- `A`  in  N  rs1 operand (dividend or multiplicand).
- `B`  in  N  rs2 operand (divisor or multiplier).
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  N  final value; held until the next accepted start or reset.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - CALC: `busy`=1; runs N iterations.
  - FIX: `busy`=1; applies sign correction and special-case selection.
  - DONE: `busy`=0, `done`=1.
- Start accept: `start`=1 in IDLE or DONE. On accept, the unit latches `op`, the magnitudes of `A`/`B`, and both sign bits, clears the counter, and goes to CALC. When `start`=0 in DONE, the unit goes to IDLE.
- Start while in CALC or FIX is ignored; latched operands are unaffected.
- Multiply (shift-add over magnitudes):
  - 2N-bit product.
  - Each iteration: if the LSB of the multiplier is set, add the multiplicand to the upper half, then shift right one bit.
  - Signedness: MUL/MULH treat both operands as signed. MULHSU treats A as signed and B as unsigned. MULHU treats both as unsigned.
  - FIX negates the 2N-bit product when the operand signs differ (signed operands only).
  - MUL returns the low N bits. MULH, MULHSU and MULHU return the high N bits.
- Divide (restoring, over magnitudes):
  - Each iteration: shift the remainder left and bring in the next dividend bit, then trial-subtract the divisor.
  - If the trial result is non-negative, keep it and set the quotient bit to 1.
- Divide sign fix in FIX:
  - Quotient is negated when the signs of A and B differ.
  - Remainder takes the sign of A.
  - Unsigned ops skip both.
- Divide special cases, resolved in FIX. Latency stays the same as normal operation.
  - B=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the original A.
  - DIV overflow (A=0x80000000, B=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- Arithmetic:
  - Magnitude of 0x80000000 is treated as the unsigned value 2^31. No saturation anywhere.
  - Iteration adder is N+1 bits wide so the trial-subtract borrow is explicit.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE, counter 0.
- Reset in any state (including mid-CALC) returns to IDLE on that edge. No `done` is produced for the aborted op.
- Fixed latency:
  - Start sampled at edge k.
  - CALC occupies cycles k+1..k+N.
  - FIX is cycle k+N+1.
  - `done`=1 in cycle k+N+2 only, i.e. 34 cycles for N=32.
- `busy` rises in the cycle after the accepting edge and falls in the DONE cycle.
- Back-to-back: a start in the DONE cycle is accepted. The next op's `done` comes N+2 cycles later, with no idle bubble.
- `result` updates only at the FIX→DONE edge. Inputs may change freely after acceptance.

## Structure
- Put the M-op codes `MD_MUL` … `MD_REMU` in the shared `defines.v`, next to the ALU select codes. The decoder and this unit both use them.
- One sub-module: `md_step`, a combinational single iteration. Inputs: accumulator/remainder, operand, and a mode bit. Outputs: next accumulator and quotient bit.
- State register, counter (log2(N)+1 bits), and sign/fix logic live in `muldiv_unit`.

## Test plan
- MUL A=7, B=0xFFFFFFFD → result 0xFFFFFFEB; `done` exactly 34 cycles after start; `busy` high for cycles 1–33.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0; all with full 34-cycle latency.
- Start pulsed in cycle 10 of a busy op with different A/B → ignored, original result returned. Start in the DONE cycle → second result 34 cycles later.
- `rst` asserted in cycle 15 of a DIV → next cycle `busy`=0, `done`=0, `result`=0; no `done` pulse afterwards.
